// File: rtl/axi_read_fsm.sv
// AXI4 read-channel slave: decodes AR requests onto the varint/raw output FIFOs and returns
// one R beat per FIFO word, status word, or error, with per-beat response and last signalling.
module axi_read_fsm #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  axs_s0_arid,
  input  logic [31:0] axs_s0_araddr,
  input  logic [7:0]  axs_s0_arlen,
  input  logic [2:0]  axs_s0_arsize,
  input  logic [1:0]  axs_s0_arburst,
  input  logic        axs_s0_arvalid,
  output logic        axs_s0_arready,
  output logic [3:0]  axs_s0_rid,
  output logic [31:0] axs_s0_rdata,
  output logic [1:0]  axs_s0_rresp,
  output logic        axs_s0_rlast,
  output logic        axs_s0_rvalid,
  input  logic        axs_s0_rready,
  input  logic        varint_out_fifo_empty,
  input  logic [31:0] varint_out_fifo_data,
  input  logic [10:0] varint_out_fifo_count,
  output logic        varint_out_fifo_pop,
  input  logic        raw_data_out_fifo_empty,
  input  logic [31:0] raw_data_out_fifo_data,
  input  logic [10:0] raw_data_out_fifo_count,
  output logic        raw_data_out_fifo_pop
);

  localparam logic [15:0] TmoLast    = 16'(TIMEOUT - 1);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;
  localparam logic [1:0]  RespDecerr = 2'b11;

  typedef enum logic [3:0] {
    StIdle   = 4'b0001,
    StSelect = 4'b0010,
    StWait   = 4'b0100,
    StResp   = 4'b1000
  } state_e;

  state_e      state_q, state_d;
  logic        ready_q;
  logic [7:0]  addr_q;
  logic [7:0]  beats_q;
  logic        size_err_q;
  logic [15:0] tmo_q;
  logic [3:0]  rid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;
  logic        rvalid_q;

  logic        is_var_data, is_var_stat, is_raw_data, is_raw_stat;
  logic        data_target, sel_empty, timeout_hit, ar_hs;
  logic [31:0] beat_data;
  logic [1:0]  beat_resp;
  logic        unused_bits;

  assign unused_bits = ^{axs_s0_araddr[31:8], axs_s0_arburst};

  assign is_var_data = (addr_q == 8'h00);
  assign is_var_stat = (addr_q == 8'h01);
  assign is_raw_data = (addr_q == 8'hF0);
  assign is_raw_stat = (addr_q == 8'hF1);
  assign data_target = ~size_err_q & (is_var_data | is_raw_data);
  assign sel_empty   = is_raw_data ? raw_data_out_fifo_empty : varint_out_fifo_empty;
  assign timeout_hit = (tmo_q == TmoLast);
  assign ar_hs       = axs_s0_arvalid & axs_s0_arready;

  // Beat contents as seen in SELECT; a size error outranks the address decode.
  always_comb begin
    beat_data = '0;
    beat_resp = RespDecerr;
    if (size_err_q) begin
      beat_resp = RespSlverr;
    end else if (is_var_data) begin
      beat_data = varint_out_fifo_data;
      beat_resp = RespOkay;
    end else if (is_raw_data) begin
      beat_data = raw_data_out_fifo_data;
      beat_resp = RespOkay;
    end else if (is_var_stat) begin
      beat_data = {21'b0, varint_out_fifo_count};
      beat_resp = RespOkay;
    end else if (is_raw_stat) begin
      beat_data = {21'b0, raw_data_out_fifo_count};
      beat_resp = RespOkay;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ar_hs) state_d = StSelect;
      StSelect: state_d = (data_target && sel_empty) ? StWait : StResp;
      // Data arriving on the timeout cycle wins over the timeout.
      StWait: begin
        if (!sel_empty)       state_d = StSelect;
        else if (timeout_hit) state_d = StResp;
      end
      StResp:   if (axs_s0_rready) state_d = rlast_q ? StIdle : StSelect;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    axs_s0_arready      = (state_q == StIdle) & ready_q;
    varint_out_fifo_pop = (state_q == StSelect) & data_target & is_var_data &
                          ~varint_out_fifo_empty & ~reset;
    raw_data_out_fifo_pop = (state_q == StSelect) & data_target & is_raw_data &
                            ~raw_data_out_fifo_empty & ~reset;
    axs_s0_rid    = rid_q;
    axs_s0_rdata  = rdata_q;
    axs_s0_rresp  = rresp_q;
    axs_s0_rlast  = rlast_q;
    axs_s0_rvalid = rvalid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      addr_q     <= '0;
      beats_q    <= '0;
      size_err_q <= 1'b0;
      tmo_q      <= '0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      rlast_q    <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (ar_hs) begin
        rid_q      <= axs_s0_arid;
        addr_q     <= axs_s0_araddr[7:0];
        beats_q    <= axs_s0_arlen;
        size_err_q <= (axs_s0_arsize != 3'b010);
      end
      if (state_q == StSelect)    tmo_q <= '0;
      else if (state_q == StWait) tmo_q <= tmo_q + 16'd1;

      if (state_q == StSelect && state_d == StResp) begin
        rdata_q  <= beat_data;
        rresp_q  <= beat_resp;
        rvalid_q <= 1'b1;
        rlast_q  <= (beats_q == 8'd0);
      end else if (state_q == StWait && state_d == StResp) begin
        rdata_q  <= '0;
        rresp_q  <= RespSlverr;
        rvalid_q <= 1'b1;
        rlast_q  <= (beats_q == 8'd0);
      end else if (state_q == StResp && axs_s0_rready) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
        if (!rlast_q) beats_q <= beats_q - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_fsm.sv
// Self-checking bench for axi_read_fsm: queue-backed FWFT FIFO models, directed scenarios and
// randomized bursts compared against beats derived from the address-map rules.
module tb_axi_read_fsm;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        var_empty = 1'b1, raw_empty = 1'b1;
  logic [31:0] var_data = '0, raw_data = '0;
  logic [10:0] var_count = '0, raw_count = '0;
  logic        var_pop, raw_pop;

  axi_read_fsm #(.TIMEOUT(TMO)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .axs_s0_arid             (arid),
    .axs_s0_araddr           (araddr),
    .axs_s0_arlen            (arlen),
    .axs_s0_arsize           (arsize),
    .axs_s0_arburst          (arburst),
    .axs_s0_arvalid          (arvalid),
    .axs_s0_arready          (arready),
    .axs_s0_rid              (rid),
    .axs_s0_rdata            (rdata),
    .axs_s0_rresp            (rresp),
    .axs_s0_rlast            (rlast),
    .axs_s0_rvalid           (rvalid),
    .axs_s0_rready           (rready),
    .varint_out_fifo_empty   (var_empty),
    .varint_out_fifo_data    (var_data),
    .varint_out_fifo_count   (var_count),
    .varint_out_fifo_pop     (var_pop),
    .raw_data_out_fifo_empty (raw_empty),
    .raw_data_out_fifo_data  (raw_data),
    .raw_data_out_fifo_count (raw_count),
    .raw_data_out_fifo_pop   (raw_pop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  beat_t       got[$];
  logic [31:0] var_q[$], raw_q[$];
  int          vectors = 0, errors = 0;
  int          pops_var = 0, pops_raw = 0, bad_pops = 0, unstable = 0;
  bit          pend_var = 0, pend_raw = 0;
  int          first_pop_cyc, first_rvalid_cyc;
  bit          timed_out;

  // Pops are observed mid-cycle and applied at the next edge, like a real FWFT FIFO.
  always @(negedge clk) begin
    pend_var = (var_pop === 1'b1);
    pend_raw = (raw_pop === 1'b1);
    if (pend_var) pops_var++;
    if (pend_raw) pops_raw++;
    if ((pend_var && var_empty) || (pend_raw && raw_empty)) bad_pops++;
  end

  always @(posedge clk) begin
    if (pend_var && var_q.size() > 0) var_q.delete(0);
    if (pend_raw && raw_q.size() > 0) raw_q.delete(0);
    var_empty <= (var_q.size() == 0);
    var_data  <= (var_q.size() > 0) ? var_q[0] : 32'h0;
    var_count <= 11'(var_q.size());
    raw_empty <= (raw_q.size() == 0);
    raw_data  <= (raw_q.size() > 0) ? raw_q[0] : 32'h0;
    raw_count <= 11'(raw_q.size());
  end

  function automatic beat_t get_beat(int i);
    return (i < got.size()) ? got[i] : '1;
  endfunction

  // Issue one AR and collect R beats; rmode 0 = rready high, 1 = toggle per valid, 2 = random.
  task automatic do_read(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input int rmode, input int push_cyc,
                         input logic [31:0] push_word);
    bit    sampled, done, held_v, tog;
    beat_t held;
    int    guard, cyc;
    got.delete();
    timed_out = 0; first_pop_cyc = -1; first_rvalid_cyc = -1;
    arid = id; araddr = {24'($urandom()), addr}; arlen = len; arsize = size;
    arburst = 2'($urandom()); arvalid = 1'b1;
    guard = 0;
    do begin
      sampled = arready;
      @(posedge clk); #1;
      guard++;
    end while (!sampled && guard < 50);
    arvalid = 1'b0;
    if (!sampled) begin
      timed_out = 1;
      return;
    end
    cyc = 1; done = 0; held_v = 0; tog = 0;
    while (!done && cyc < 200) begin
      if ((var_pop || raw_pop) && first_pop_cyc < 0) first_pop_cyc = cyc;
      if (cyc == push_cyc) var_q.push_back(push_word);
      if (rvalid) begin
        if (first_rvalid_cyc < 0) first_rvalid_cyc = cyc;
        if (held_v && held !== {rdata, rresp, rlast, rid}) unstable++;
        case (rmode)
          0:       rready = 1'b1;
          1:       begin rready = !tog; tog = !tog; end
          default: rready = 1'($urandom_range(0, 1));
        endcase
        held   = {rdata, rresp, rlast, rid};
        held_v = !rready;
        if (rready) begin
          got.push_back(held);
          done = rlast;
        end
      end else begin
        if (held_v) unstable++;
        rready = 1'b0;
        held_v = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    if (!done) timed_out = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; arvalid = 1'b0; rready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({arready, rvalid, rlast, rresp, rid, rdata, var_pop, raw_pop} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ar=%b rv=%b rl=%b rr=%b id=%h d=%h pops=%b%b want all 0",
               arready, rvalid, rlast, rresp, rid, rdata, var_pop, raw_pop);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (arready !== 1'b1) begin
      errors++; $display("FAIL arready_after_reset: got %b want 1", arready);
    end
  endtask

  task automatic test_single();
    int p0 = pops_var;
    var_q.push_back(32'hDEADBEEF);
    @(posedge clk); #1;
    do_read(4'h9, 8'h00, 8'd0, 3'b010, 0, -1, '0);
    vectors++;
    if (timed_out !== 1'b0 || got.size() !== 1) begin
      errors++; $display("FAIL single_count: got %0d beats (to=%b) want 1", got.size(), timed_out);
    end
    vectors++;
    if (get_beat(0) !== {32'hDEADBEEF, 2'b00, 1'b1, 4'h9}) begin
      errors++; $display("FAIL single_beat: got %h want %h", get_beat(0),
                         {32'hDEADBEEF, 2'b00, 1'b1, 4'h9});
    end
    vectors++;
    if (first_pop_cyc !== 1 || first_rvalid_cyc !== 2) begin
      errors++; $display("FAIL single_timing: got pop@%0d rvalid@%0d want 1 and 2",
                         first_pop_cyc, first_rvalid_cyc);
    end
    vectors++;
    if (pops_var - p0 !== 1) begin
      errors++; $display("FAIL single_pops: got %0d want 1", pops_var - p0);
    end
    vectors++;
    if (arready !== 1'b1) begin
      errors++; $display("FAIL single_arready_back: got %b want 1", arready);
    end
  endtask

  task automatic test_burst();
    logic [31:0] exp[4];
    int pr = pops_raw, pv = pops_var;
    for (int i = 0; i < 4; i++) begin
      exp[i] = $urandom();
      raw_q.push_back(exp[i]);
    end
    @(posedge clk); #1;
    do_read(4'h3, 8'hF0, 8'd3, 3'b010, 1, -1, '0);
    vectors++;
    if (timed_out !== 1'b0 || got.size() !== 4) begin
      errors++; $display("FAIL burst_count: got %0d beats want 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (get_beat(i) !== {exp[i], 2'b00, (i == 3), 4'h3}) begin
        errors++; $display("FAIL burst_beat%0d: got %h want %h", i, get_beat(i),
                           {exp[i], 2'b00, (i == 3), 4'h3});
      end
    end
    vectors++;
    if (pops_raw - pr !== 4 || pops_var - pv !== 0) begin
      errors++; $display("FAIL burst_pops: got raw %0d var %0d want 4 and 0",
                         pops_raw - pr, pops_var - pv);
    end
    vectors++;
    if (unstable !== 0) begin
      errors++; $display("FAIL burst_stable: got %0d changes while stalled want 0", unstable);
    end
  endtask

  task automatic test_status();
    int p0 = pops_var;
    var_q.delete();
    for (int i = 0; i < 17; i++) var_q.push_back($urandom());
    @(posedge clk); #1;
    do_read(4'hA, 8'h01, 8'd0, 3'b010, 0, -1, '0);
    vectors++;
    if (get_beat(0) !== {32'h11, 2'b00, 1'b1, 4'hA} || got.size() !== 1) begin
      errors++; $display("FAIL status_beat: got %h (%0d beats) want %h", get_beat(0), got.size(),
                         {32'h11, 2'b00, 1'b1, 4'hA});
    end
    vectors++;
    if (pops_var - p0 !== 0) begin
      errors++; $display("FAIL status_pops: got %0d want 0", pops_var - p0);
    end
    var_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int p0 = pops_var;
    do_read(4'h1, 8'h00, 8'd0, 3'b010, 0, -1, '0);
    vectors++;
    if (get_beat(0) !== {32'h0, 2'b10, 1'b1, 4'h1} || got.size() !== 1) begin
      errors++; $display("FAIL timeout_beat: got %h want %h", get_beat(0),
                         {32'h0, 2'b10, 1'b1, 4'h1});
    end
    vectors++;
    if (first_rvalid_cyc !== int'(TMO) + 2 || pops_var - p0 !== 0) begin
      errors++; $display("FAIL timeout_timing: got rvalid@%0d pops %0d want %0d and 0",
                         first_rvalid_cyc, pops_var - p0, TMO + 2);
    end
    // Word becomes visible on the last WAIT cycle, coinciding with the timeout.
    p0 = pops_var;
    do_read(4'h2, 8'h00, 8'd0, 3'b010, 0, TMO, 32'hCAFE0001);
    vectors++;
    if (get_beat(0) !== {32'hCAFE0001, 2'b00, 1'b1, 4'h2} || got.size() !== 1) begin
      errors++; $display("FAIL timeout_coincide: got %h want %h", get_beat(0),
                         {32'hCAFE0001, 2'b00, 1'b1, 4'h2});
    end
    vectors++;
    if (first_rvalid_cyc !== int'(TMO) + 3 || pops_var - p0 !== 1) begin
      errors++; $display("FAIL coincide_timing: got rvalid@%0d pops %0d want %0d and 1",
                         first_rvalid_cyc, pops_var - p0, TMO + 3);
    end
    // First beat times out, second beat retries and finds data.
    p0 = pops_var;
    do_read(4'h4, 8'h00, 8'd1, 3'b010, 0, TMO + 2, 32'h0BAD_F00D);
    vectors++;
    if (get_beat(0) !== {32'h0, 2'b10, 1'b0, 4'h4} ||
        get_beat(1) !== {32'h0BADF00D, 2'b00, 1'b1, 4'h4} || got.size() !== 2) begin
      errors++; $display("FAIL timeout_retry: got %h %h want %h %h", get_beat(0), get_beat(1),
                         {32'h0, 2'b10, 1'b0, 4'h4}, {32'h0BADF00D, 2'b00, 1'b1, 4'h4});
    end
    vectors++;
    if (pops_var - p0 !== 1) begin
      errors++; $display("FAIL retry_pops: got %0d want 1", pops_var - p0);
    end
  endtask

  task automatic test_errors();
    int p0 = pops_var;
    var_q.push_back(32'h11112222);
    @(posedge clk); #1;
    do_read(4'h6, 8'h42, 8'd1, 3'b010, 0, -1, '0);
    vectors++;
    if (get_beat(0) !== {32'h0, 2'b11, 1'b0, 4'h6} || get_beat(1) !== {32'h0, 2'b11, 1'b1, 4'h6}
        || got.size() !== 2) begin
      errors++; $display("FAIL decerr_beats: got %h %h (%0d beats) want DECERR x2", get_beat(0),
                         get_beat(1), got.size());
    end
    do_read(4'h7, 8'h00, 8'd0, 3'b001, 0, -1, '0);
    vectors++;
    if (get_beat(0) !== {32'h0, 2'b10, 1'b1, 4'h7} || got.size() !== 1) begin
      errors++; $display("FAIL size_slverr: got %h want %h", get_beat(0),
                         {32'h0, 2'b10, 1'b1, 4'h7});
    end
    vectors++;
    if (pops_var - p0 !== 0) begin
      errors++; $display("FAIL error_pops: got %0d want 0", pops_var - p0);
    end
    var_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp[4];
    int p0 = pops_var, pr, guard;
    for (int i = 0; i < 4; i++) begin
      exp[i] = $urandom();
      var_q.push_back(exp[i]);
    end
    @(posedge clk); #1;
    arid = 4'h5; araddr = '0; arlen = 8'd3; arsize = 3'b010; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    guard = 0;
    while (!rvalid && guard < 20) begin @(posedge clk); #1; guard++; end
    vectors++;
    if (rvalid !== 1'b1 || rdata !== exp[0]) begin
      errors++; $display("FAIL rstmid_beat1: got v=%b d=%h want 1 %h", rvalid, rdata, exp[0]);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    guard = 0;
    while (!rvalid && guard < 20) begin @(posedge clk); #1; guard++; end
    vectors++;
    if (rvalid !== 1'b1 || rdata !== exp[1]) begin
      errors++; $display("FAIL rstmid_beat2: got v=%b d=%h want 1 %h", rvalid, rdata, exp[1]);
    end
    reset = 1'b1;
    pr = pops_var;
    @(posedge clk); #1;
    vectors++;
    if (rvalid !== 1'b0 || arready !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: got rvalid %b arready %b want 0 0", rvalid, arready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (arready !== 1'b1 || pops_var !== pr || pops_var - p0 !== 2) begin
      errors++; $display("FAIL rstmid_recover: got arready %b pops %0d (%0d in reset) want 1 2 0",
                         arready, pops_var - p0, pops_var - pr);
    end
    do_read(4'hB, 8'h00, 8'd0, 3'b010, 0, -1, '0);
    vectors++;
    if (get_beat(0) !== {exp[2], 2'b00, 1'b1, 4'hB} || got.size() !== 1) begin
      errors++; $display("FAIL rstmid_newread: got %h want %h", get_beat(0),
                         {exp[2], 2'b00, 1'b1, 4'hB});
    end
    var_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    beat_t       exp[$];
    logic [7:0]  addr, len;
    logic [2:0]  size;
    logic [3:0]  id;
    logic [31:0] d;
    int          pv, pr, exp_pv, exp_pr, sel;
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: addr = 8'h00;
        1: addr = 8'h01;
        2: addr = 8'hF0;
        3: addr = 8'hF1;
        default: begin
          do addr = 8'($urandom());
          while (addr == 8'h00 || addr == 8'h01 || addr == 8'hF0 || addr == 8'hF1);
        end
      endcase
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      len  = 8'($urandom_range(0, 5));
      id   = 4'($urandom());
      var_q.delete(); raw_q.delete();
      repeat ($urandom_range(0, 3)) var_q.push_back($urandom());
      repeat ($urandom_range(0, 3)) raw_q.push_back($urandom());
      while (var_q.size() <= int'(len)) var_q.push_back($urandom());
      while (raw_q.size() <= int'(len)) raw_q.push_back($urandom());
      exp.delete(); exp_pv = 0; exp_pr = 0;
      for (int i = 0; i <= int'(len); i++) begin
        if (size != 3'b010)    exp.push_back({32'h0, 2'b10, (i == int'(len)), id});
        else if (addr == 8'h00) begin exp.push_back({var_q[i], 2'b00, (i == int'(len)), id});
                                      exp_pv++; end
        else if (addr == 8'hF0) begin exp.push_back({raw_q[i], 2'b00, (i == int'(len)), id});
                                      exp_pr++; end
        else if (addr == 8'h01) begin d = 32'(var_q.size());
                                      exp.push_back({d, 2'b00, (i == int'(len)), id}); end
        else if (addr == 8'hF1) begin d = 32'(raw_q.size());
                                      exp.push_back({d, 2'b00, (i == int'(len)), id}); end
        else                   exp.push_back({32'h0, 2'b11, (i == int'(len)), id});
      end
      @(posedge clk); #1;
      pv = pops_var; pr = pops_raw;
      do_read(id, addr, len, size, 2, -1, '0);
      vectors++;
      if (timed_out !== 1'b0 || got.size() !== exp.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d beats want %0d (addr %h size %b)", t,
                           got.size(), exp.size(), addr, size);
      end
      for (int i = 0; i < exp.size(); i++) begin
        vectors++;
        if (get_beat(i) !== exp[i]) begin
          errors++; $display("FAIL rand%0d_beat%0d: got %h want %h", t, i, get_beat(i), exp[i]);
        end
      end
      vectors++;
      if (pops_var - pv !== exp_pv || pops_raw - pr !== exp_pr) begin
        errors++; $display("FAIL rand%0d_pops: got var %0d raw %0d want %0d %0d", t,
                           pops_var - pv, pops_raw - pr, exp_pv, exp_pr);
      end
    end
    vectors++;
    if (unstable !== 0 || bad_pops !== 0) begin
      errors++; $display("FAIL rand_integrity: got %0d unstable %0d empty-pops want 0 0",
                         unstable, bad_pops);
    end
  endtask

  initial begin
    rready = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_status();
    test_timeout();
    test_errors();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want completion before time limit");
    $fatal(1, "watchdog");
  end

endmodule
